// File: rtl/encoder_4x2_buf.sv
// Registered 4-to-2 priority encoder with valid/ready input and output FIFO.
// Define ENCODER_4X2_RR_EN for round-robin priority instead of fixed.
module encoder_4x2_buf #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] d,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] q,
  output logic       multi,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       zero_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_C = (PTR_W+1)'(1);

  logic [2:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_nxt;
  logic [PTR_W:0]   count;
  logic [1:0]       enc;
  logic             multi_c;
  logic             accept;
  logic             push;
  logic             pop;

  assign in_ready  = en & (count != FULL_C);
  assign out_valid = (count != '0);
  assign accept    = in_valid & in_ready;
  assign push      = accept & (|d);
  assign pop       = out_valid & out_ready;
  assign rd_nxt    = rd_ptr + 1'b1;
  assign multi_c   = ($countones(d) >= 2);

`ifdef ENCODER_4X2_RR_EN
  logic [1:0] rr;
  logic [7:0] dd;
  logic [3:0] rot;

  // rot[k] is request (rr+k) mod 4, so the lowest set bit wins
  assign dd  = {d, d};
  assign rot = dd[rr +: 4];

  always_comb begin
    enc = rr;
    if (rot[0])      enc = rr;
    else if (rot[1]) enc = rr + 2'd1;
    else if (rot[2]) enc = rr + 2'd2;
    else if (rot[3]) enc = rr + 2'd3;
  end

  always_ff @(posedge clk) begin
    if (rst)       rr <= '0;
    else if (push) rr <= enc + 2'd1;
  end
`else
  always_comb begin
    enc = 2'd0;
    if (d[3])      enc = 2'd3;
    else if (d[2]) enc = 2'd2;
    else if (d[1]) enc = 2'd1;
    else           enc = 2'd0;
  end
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {multi_c, enc};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      q        <= 2'b00;
      multi    <= 1'b0;
      zero_err <= 1'b0;
    end else begin
      zero_err <= accept & ~(|d);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_nxt;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // head register tracks the entry that will sit at rd_ptr
      if (push && (count == '0 || (pop && count == ONE_C)))
        {multi, q} <= {multi_c, enc};
      else if (pop && count > ONE_C)
        {multi, q} <= mem[rd_nxt];
    end
  end

endmodule
